conv_window_reader: RTL and testbench

Read-side initiator for convolution input fetches. It walks the output-position and kernel-tap loops of a stride-1, pad-1 convolution and issues one word read per tap to input memory. It tracks outstanding reads and returns, aligned with each read response, the loop indices (i, j, wi, wj) that produced it. Those returned indices drive the padding checker, which zeroes out-of-bounds taps downstream of this block.

---
 rtl/conv_window_reader.sv | 191 +++++++++++++++++++
 tb/tb_conv_window_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_reader.sv
// Read-side initiator for a stride-1, pad-1 convolution: walks the output/tap loop nest,
// issues one word read per tap, and returns each tap's indices aligned with its in-order response.
module conv_window_reader #(
  parameter int MAX_OUTST = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [31:0]        base_i,
  input  logic [31:0]        iw_i,
  input  logic [31:0]        ih_i,
  input  logic [31:0]        k_i,
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  output logic signed [31:0] loop_i_o,
  output logic signed [31:0] loop_j_o,
  output logic signed [31:0] loop_wi_o,
  output logic signed [31:0] loop_wj_o,
  output logic               out_valid_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [31:0]        base_q;
  logic signed [31:0] iw_q, ih_q, k_q;
  logic signed [31:0] i_q, j_q, wi_q, wj_q;
  logic signed [31:0] i_nxt, j_nxt, wi_nxt, wj_nxt;
  logic               req_q;
  logic [31:0]        addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic signed [31:0] fifo_i  [MAX_OUTST];
  logic signed [31:0] fifo_j  [MAX_OUTST];
  logic signed [31:0] fifo_wi [MAX_OUTST];
  logic signed [31:0] fifo_wj [MAX_OUTST];

  logic start_acc, cfg_zero, fifo_full, fifo_empty, push, pop;
  logic last_wi, last_wj, last_i, last_j, last_tap;

  // Padded taps (any coordinate outside the plane) read the base word; downstream zeroes them.
  function automatic logic [31:0] tap_addr(input logic [31:0] base,
                                           input logic signed [31:0] x, y, w, h);
    if (x == -32'sd1 || y == -32'sd1 || x >= w || y >= h) return base;
    return base + ((y * w + x) << 2);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign start_acc  = (state == IDLE) && start_i;
  assign cfg_zero   = (iw_i == '0) || (ih_i == '0) || (k_i == '0);
  assign fifo_full  = (cnt_q == CNT_MAX);
  assign fifo_empty = (cnt_q == '0);
  assign mem_req_o  = req_q && !fifo_full;
  assign mem_addr_o = addr_q;
  assign push       = mem_req_o && mem_gnt_i;
  assign pop        = mem_rvalid_i && !fifo_empty;

  assign last_wi  = (wi_q == k_q - 32'sd2);
  assign last_wj  = (wj_q == k_q - 32'sd2);
  assign last_i   = (i_q == iw_q - 32'sd1);
  assign last_j   = (j_q == ih_q - 32'sd1);
  assign last_tap = last_wi && last_wj && last_i && last_j;

  always_comb begin
    wi_nxt = wi_q + 32'sd1;
    wj_nxt = wj_q;
    i_nxt  = i_q;
    j_nxt  = j_q;
    if (last_wi) begin
      wi_nxt = -32'sd1;
      wj_nxt = wj_q + 32'sd1;
      if (last_wj) begin
        wj_nxt = -32'sd1;
        i_nxt  = i_q + 32'sd1;
        if (last_i) begin
          i_nxt = '0;
          j_nxt = j_q + 32'sd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      base_q <= base_i;
      iw_q   <= iw_i;
      ih_q   <= ih_i;
      k_q    <= k_i;
    end
  end

  // The request register holds the current tap; it only moves on grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
      wi_q   <= '0;
      wj_q   <= '0;
    end else if (start_acc) begin
      req_q  <= !cfg_zero;
      addr_q <= base_i;
      i_q    <= '0;
      j_q    <= '0;
      wi_q   <= -32'sd1;
      wj_q   <= -32'sd1;
    end else if (push) begin
      i_q  <= i_nxt;
      j_q  <= j_nxt;
      wi_q <= wi_nxt;
      wj_q <= wj_nxt;
      if (last_tap) req_q <= 1'b0;
      else addr_q <= tap_addr(base_q, i_nxt + wi_nxt, j_nxt + wj_nxt, iw_q, ih_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_i[wr_ptr]  <= i_q;
      fifo_j[wr_ptr]  <= j_q;
      fifo_wi[wr_ptr] <= wi_q;
      fifo_wj[wr_ptr] <= wj_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    loop_i_o  = '0;
    loop_j_o  = '0;
    loop_wi_o = '0;
    loop_wj_o = '0;
    if (!fifo_empty) begin
      loop_i_o  = fifo_i[rd_ptr];
      loop_j_o  = fifo_j[rd_ptr];
      loop_wi_o = fifo_wi[rd_ptr];
      loop_wj_o = fifo_wj[rd_ptr];
    end
  end

  assign out_valid_o = pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = cfg_zero ? DONE : RUN;
      RUN:     if (push && last_tap) state_nxt = DRAIN;
      DRAIN:   if (pop && cnt_q == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == RUN) || (state == DRAIN);
    done_o = (state == DONE);
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// Randomized bench for conv_window_reader: a loop-nest reference model feeds a scoreboard
// checked on every grant (address) and every response (indices).
module tb_conv_window_reader;

  localparam int MAX_OUTST = 4;

  typedef struct {
    int          i;
    int          j;
    int          wi;
    int          wj;
    logic [31:0] addr;
  } tap_t;

  logic               clk, rst, start, gnt, rvalid, req, out_valid, busy, done;
  logic [31:0]        base, iw, ih, k, addr;
  logic signed [31:0] li, lj, lwi, lwj;

  conv_window_reader #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .iw_i(iw), .ih_i(ih), .k_i(k),
    .mem_req_o(req), .mem_addr_o(addr), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
    .loop_i_o(li), .loop_j_o(lj), .loop_wi_o(lwi), .loop_wj_o(lwj),
    .out_valid_o(out_valid), .busy_o(busy), .done_o(done)
  );

  tap_t        exp_q[$];
  tap_t        resp_q[$];
  logic [31:0] grant_log [4096];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, grant_cnt = 0, done_cnt = 0, fifo_cnt = 0;
  int t_start = 0, t_done = 0;
  int gnt_mode = 0, rv_mode = 0;
  bit busy_seen = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory side: grant and response behaviour selected by the mode variables.
  initial begin
    gnt = 1'b0;
    rvalid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      gnt = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (rv_mode)
        1:       rvalid = (fifo_cnt > 0);
        2:       rvalid = (fifo_cnt > 0) && ($urandom_range(0, 2) != 0);
        3:       rvalid = 1'b1;
        default: rvalid = 1'b0;
      endcase
    end
  end

  // Monitor: checks each grant against the model and each response against issued taps.
  initial begin
    tap_t        e;
    bit          prev_stall;
    logic [31:0] prev_addr;
    bit          g, p;
    prev_stall = 0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        g = req && gnt;
        p = rvalid && (fifo_cnt > 0);
        chk("out_valid", out_valid, p);
        if (p) begin
          if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
          else begin
            e = resp_q.pop_front();
            chk("idx_i", li, e.i);
            chk("idx_j", lj, e.j);
            chk("idx_wi", lwi, e.wi);
            chk("idx_wj", lwj, e.wj);
          end
        end
        if (fifo_cnt == MAX_OUTST) chk("throttle_req", req, 0);
        if (prev_stall) begin
          chk("hold_req", req, 1);
          chk("hold_addr", addr, prev_addr);
        end
        if (g) begin
          if (grant_cnt < 4096) grant_log[grant_cnt] = addr;
          grant_cnt++;
          if (exp_q.size() == 0) chk("extra_req", grant_cnt, 0);
          else begin
            e = exp_q.pop_front();
            chk("addr", addr, e.addr);
            resp_q.push_back(e);
          end
        end
        prev_stall = req && !gnt;
        prev_addr  = addr;
        fifo_cnt   = fifo_cnt + (g ? 1 : 0) - (p ? 1 : 0);
        if (done) begin
          done_cnt++;
          t_done = cyc;
        end
        if (busy) busy_seen = 1;
      end
    end
  end

  task automatic build_job(input logic [31:0] b, input int w, input int h, input int kk);
    tap_t t;
    int x, y;
    for (int jj = 0; jj < h; jj++)
      for (int ii = 0; ii < w; ii++)
        for (int wjj = -1; wjj <= kk - 2; wjj++)
          for (int wii = -1; wii <= kk - 2; wii++) begin
            x = ii + wii;
            y = jj + wjj;
            t.i = ii; t.j = jj; t.wi = wii; t.wj = wjj;
            if (x < 0 || y < 0 || x >= w || y >= h) t.addr = b;
            else t.addr = b + 32'((y * w + x) * 4);
            exp_q.push_back(t);
          end
  endtask

  task automatic start_job(input logic [31:0] b, input int w, input int h, input int kk,
                           output int g0, output int d0, output int total);
    build_job(b, w, h, kk);
    total = w * h * kk * kk;
    @(posedge clk);
    #1;
    g0 = grant_cnt;
    d0 = done_cnt;
    busy_seen = 0;
    base = b; iw = w; ih = h; k = kk;
    start = 1'b1;
    t_start = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    base = $urandom; iw = $urandom; ih = $urandom; k = $urandom;
  endtask

  task automatic finish_job(input int total, input int g0, input int d0, output int dt);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("done_pulses", done_cnt - d0, 1);
    chk("req_count", grant_cnt - g0, total);
    chk("model_drained", exp_q.size(), 0);
    chk("resp_drained", resp_q.size(), 0);
    chk("idle_busy", busy, 0);
    dt = t_done - t_start;
  endtask

  initial begin
    int g0, d0, total, dt, n, w, h, kk;
    logic [31:0] b;
    rst = 1'b1; start = 1'b0;
    base = '0; iw = '0; ih = '0; k = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_loop_i", li, 0);
    chk("rst_loop_j", lj, 0);
    chk("rst_loop_wi", lwi, 0);
    chk("rst_loop_wj", lwj, 0);

    // 4x3 image, always-grant, one-cycle responses
    gnt_mode = 0; rv_mode = 1;
    start_job(32'h1000, 4, 3, 3, g0, d0, total);
    finish_job(total, g0, d0, dt);
    chk("t1_grants", grant_cnt - g0, 108);
    chk("t1_first_addr", grant_log[g0], 32'h1000);
    chk("t1_addr_j1i2", grant_log[g0 + 59], 32'h101C);
    chk("t1_addr_i3_pad", grant_log[g0 + 32], 32'h1000);
    chk("t1_done_latency", dt, 110);

    // Outstanding throttle with responses withheld
    gnt_mode = 0; rv_mode = 0;
    start_job(32'h2000, 2, 2, 3, g0, d0, total);
    repeat (20) begin @(posedge clk); #1; end
    chk("t2_grants_at_limit", grant_cnt - g0, MAX_OUTST);
    chk("t2_req_low", req, 0);
    chk("t2_busy", busy, 1);
    rv_mode = 1;
    finish_job(total, g0, d0, dt);

    // Grant backpressure and random response timing, then random shapes
    gnt_mode = 1; rv_mode = 2;
    start_job(32'h8000_0000, 5, 4, 3, g0, d0, total);
    finish_job(total, g0, d0, dt);
    for (int r = 0; r < 3; r++) begin
      w  = $urandom_range(1, 4);
      h  = $urandom_range(1, 3);
      kk = 2 * $urandom_range(0, 2) + 1;
      b  = $urandom;
      start_job(b, w, h, kk, g0, d0, total);
      finish_job(total, g0, d0, dt);
    end

    // Zero-size jobs
    gnt_mode = 0; rv_mode = 1;
    start_job(32'h3000, 0, 3, 3, g0, d0, total);
    finish_job(total, g0, d0, dt);
    chk("t4_done_latency", dt, 1);
    chk("t4_busy_never", busy_seen, 0);
    start_job(32'h3000, 4, 2, 0, g0, d0, total);
    finish_job(total, g0, d0, dt);
    chk("t4k_done_latency", dt, 1);

    // Reset mid-job followed by stale responses
    gnt_mode = 0; rv_mode = 1;
    start_job(32'h4000, 3, 3, 3, g0, d0, total);
    n = 0;
    while (grant_cnt - g0 < 10 && n < 200) begin @(posedge clk); #1; n++; end
    chk("t5_ten_grants", (grant_cnt - g0) >= 10, 1);
    rst = 1'b1; rv_mode = 3;
    exp_q.delete(); resp_q.delete(); fifo_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rv_mode = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_req_idle", req, 0);
    chk("t5_busy_idle", busy, 0);
    rv_mode = 1;
    start_job(32'h4400, 3, 3, 3, g0, d0, total);
    finish_job(total, g0, d0, dt);
    chk("t5_restart_first", grant_log[g0], 32'h4400);

    // start pulses during RUN and DRAIN are ignored
    gnt_mode = 0; rv_mode = 2;
    start_job(32'h5000, 3, 2, 3, g0, d0, total);
    n = 0;
    while (grant_cnt - g0 < 5 && n < 200) begin @(posedge clk); #1; n++; end
    base = 32'hDEAD_0000; iw = 1; ih = 1; k = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (grant_cnt - g0 < total && n < 1000) begin @(posedge clk); #1; n++; end
    rv_mode = 0;
    chk("t6_drain_busy", busy, 1);
    chk("t6_drain_req", req, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rv_mode = 2;
    finish_job(total, g0, d0, dt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
